// File: rtl/onehot_enc_pkg.sv
// Shared defaults and the lowest-set-bit helper for the one-hot encoder/checker.
// The helper is sized for the widest supported word; callers zero-extend into it.
package onehot_enc_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_CODE_W = 4;
    localparam int DEF_CNT_W  = 16;
    localparam int MAX_WIDTH  = 64;

    function automatic logic [5:0] lowest_set_idx(input logic [MAX_WIDTH-1:0] word);
        logic [5:0] idx;
        idx = 6'd0;
        // Scan downward so the last hit is the lowest set bit.
        for (int i = MAX_WIDTH - 1; i >= 0; i--) begin
            if (word[i]) begin
                idx = 6'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter
    import onehot_enc_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {CNT_W{1'b0}};
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/onehot_enc_check.sv
// Two-stage valid/ready pipeline that encodes a one-hot word to its lowest set index,
// flags empty or multi-hot words, and keeps saturating transfer/error statistics.
module onehot_enc_check
    import onehot_enc_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int CODE_W = DEF_CODE_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  onehot,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] code,
    output logic              zero,
    output logic              multi,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  xfer_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    logic              s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]  s1_data_q, s1_data_d;
    logic              s2_valid_q, s2_valid_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              zero_q, zero_d;
    logic              multi_q, multi_d;

    logic              out_xfer_s;
    logic              s1_adv_s;
    logic              in_ready_s;
    logic              err_inc_s;
    logic [CODE_W-1:0] enc_code_s;
    logic              enc_zero_s;
    logic              enc_multi_s;

    assign out_xfer_s = s2_valid_q && out_ready;
    assign s1_adv_s   = !s2_valid_q || out_xfer_s;
    assign in_ready_s = !s1_valid_q || s1_adv_s;
    assign err_inc_s  = out_xfer_s && (zero_q || multi_q);

    // Clearing the lowest set bit leaves something behind only for two or more bits.
    assign enc_code_s  = CODE_W'(lowest_set_idx(MAX_WIDTH'(s1_data_q)));
    assign enc_zero_s  = (s1_data_q == {WIDTH{1'b0}});
    assign enc_multi_s = |(s1_data_q & (s1_data_q - {{(WIDTH-1){1'b0}}, 1'b1}));

    // Pipeline next-state: stage 1 refills whenever it can accept, stage 2 when stage 1 advances.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s2_valid_d = s2_valid_q;
        code_d     = code_q;
        zero_d     = zero_q;
        multi_d    = multi_q;
        if (in_ready_s) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d = onehot;
            end else begin
                s1_data_d = s1_data_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (s1_adv_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                code_d  = enc_code_s;
                zero_d  = enc_zero_s;
                multi_d = enc_multi_s;
            end else begin
                code_d  = code_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= {WIDTH{1'b0}};
            s2_valid_q <= 1'b0;
            code_q     <= {CODE_W{1'b0}};
            zero_q     <= 1'b0;
            multi_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s2_valid_q <= s2_valid_d;
            code_q     <= code_d;
            zero_q     <= zero_d;
            multi_q    <= multi_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_xfer_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt),
        .inc   (out_xfer_s),
        .count (xfer_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_cnt),
        .inc   (err_inc_s),
        .count (err_cnt)
    );

    assign in_ready  = in_ready_s;
    assign out_valid = s2_valid_q;
    assign code      = code_q;
    assign zero      = zero_q;
    assign multi     = multi_q;

endmodule

// File: tb/tb_onehot_enc_check.sv
// Scoreboard bench: a 16-bit-counter and a 4-bit-counter instance share one stimulus stream.
module tb_onehot_enc_check;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] onehot;
    logic        out_ready;
    logic        clr_cnt;

    logic        in_ready, out_valid, zero, multi;
    logic [3:0]  code;
    logic [15:0] xfer_cnt, err_cnt;
    logic        in_ready4, out_valid4, zero4, multi4;
    logic [3:0]  code4;
    logic [3:0]  xfer_cnt4, err_cnt4;

    typedef struct packed {
        logic [3:0] code;
        logic       zero;
        logic       multi;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   mdl_xfer = 0;
    int   mdl_err = 0;

    onehot_enc_check #(.WIDTH(16), .CODE_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .onehot(onehot), .out_valid(out_valid), .out_ready(out_ready),
        .code(code), .zero(zero), .multi(multi), .clr_cnt(clr_cnt),
        .xfer_cnt(xfer_cnt), .err_cnt(err_cnt)
    );

    onehot_enc_check #(.WIDTH(16), .CODE_W(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .onehot(onehot), .out_valid(out_valid4), .out_ready(out_ready),
        .code(code4), .zero(zero4), .multi(multi4), .clr_cnt(clr_cnt),
        .xfer_cnt(xfer_cnt4), .err_cnt(err_cnt4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic exp_t ref_model(input logic [15:0] w);
        exp_t e;
        int   pop = 0;
        int   low = -1;
        for (int i = 0; i < 16; i++) begin
            if (w[i]) begin
                pop++;
                if (low < 0) low = i;
            end
        end
        e.code  = (low < 0) ? 4'd0 : 4'(low);
        e.zero  = (pop == 0);
        e.multi = (pop >= 2);
        return e;
    endfunction

    function automatic logic [63:0] sat(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? 64'(mx) : 64'(n);
    endfunction

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        case ($urandom % 4)
            0: w = 16'h0001 << ($urandom % 16);
            1: w = 16'h0000;
            2: w = 16'($urandom);
            default: w = (16'h0001 << ($urandom % 16)) | (16'h0001 << ($urandom % 16));
        endcase
        return w;
    endfunction

    // Stimulus side of the scoreboard: every accepted word queues its expected result.
    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1 && in_valid && in_ready) exp_q.push_back(ref_model(onehot));
    end

    // Monitor: counter model, output comparison and stall stability.
    initial begin
        exp_t        e;
        logic        stall_prev;
        logic [3:0]  prev_code;
        logic        prev_zero, prev_multi;
        stall_prev = 1'b0;
        prev_code = 4'd0; prev_zero = 1'b0; prev_multi = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                exp_q.delete();
                mdl_xfer = 0;
                mdl_err = 0;
                stall_prev = 1'b0;
            end else begin
                chk("xfer_cnt", xfer_cnt, sat(mdl_xfer, 16));
                chk("err_cnt", err_cnt, sat(mdl_err, 16));
                chk("xfer_cnt4", xfer_cnt4, sat(mdl_xfer, 4));
                chk("err_cnt4", err_cnt4, sat(mdl_err, 4));
                if (stall_prev) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_code", code, prev_code);
                    chk("stall_zero", zero, prev_zero);
                    chk("stall_multi", multi, prev_multi);
                end
                if (out_valid && out_ready) begin
                    chk("output_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("code", code, e.code);
                        chk("zero", zero, e.zero);
                        chk("multi", multi, e.multi);
                        chk("valid4", out_valid4, 1);
                        chk("code4", code4, e.code);
                        chk("flags4", {zero4, multi4}, {e.zero, e.multi});
                        if (clr_cnt) begin
                            mdl_xfer = 0;
                            mdl_err = 0;
                        end else begin
                            mdl_xfer++;
                            if (e.zero || e.multi) mdl_err++;
                        end
                    end
                end else if (clr_cnt) begin
                    mdl_xfer = 0;
                    mdl_err = 0;
                end
                stall_prev = out_valid && !out_ready;
                prev_code = code; prev_zero = zero; prev_multi = multi;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] w);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        onehot = w;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            cyc();
        end
        in_valid = 1'b0;
        chk("send_accepted", acc, 1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int t = 0; t < 100 && (exp_q.size() != 0 || out_valid); t++) cyc();
        chk("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   accepts;
        int   seen;
        logic pending;
        rst_n = 1'b0; in_valid = 1'b0; onehot = 16'h0000; out_ready = 1'b0; clr_cnt = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_flags", {code, zero, multi}, 6'd0);
        chk("rst_counters", {xfer_cnt, err_cnt}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("in_ready_after_reset", in_ready, 1);

        // Single word latency.
        out_ready = 1'b1;
        in_valid = 1'b1; onehot = 16'h0010;
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_cycle1_valid", out_valid, 0);
        cyc();
        @(negedge clk);
        chk("lat_cycle2_valid", out_valid, 1);
        chk("lat_cycle2_code", code, 4);
        cyc();
        @(negedge clk);
        chk("lat_xfer_cnt", xfer_cnt, 1);
        chk("lat_err_cnt", err_cnt, 0);
        cyc();

        send(16'h0001); send(16'h0000); send(16'h0505);
        drain();
        for (int i = 0; i < 16; i++) send(16'h0001 << i);
        drain();

        // Output stall with input held valid.
        out_ready = 1'b0;
        accepts = 0;
        pending = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            if (!pending) onehot = rand_word();
            @(negedge clk);
            if (in_ready) accepts++;
            pending = !in_ready;
            cyc();
        end
        chk("stall_accepts", accepts, 2);
        chk("stall_in_ready", {in_ready, in_ready4}, 2'b00);
        in_valid = 1'b0;
        drain();

        pending = 1'b0;
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom % 10) < 7;
            clr_cnt = ($urandom % 40) == 0;
            if (!pending) begin
                in_valid = ($urandom % 10) < 7;
                onehot = rand_word();
            end
            @(negedge clk);
            pending = in_valid && !in_ready;
            cyc();
        end
        in_valid = 1'b0; clr_cnt = 1'b0;
        drain();

        // Counter saturation from a cleared start.
        clr_cnt = 1'b1;
        cyc();
        clr_cnt = 1'b0;
        for (int i = 0; i < 20; i++) send((i % 2 == 0) ? 16'h0000 : 16'h0003);
        drain();
        @(negedge clk);
        chk("sat_err_cnt4", err_cnt4, 15);
        chk("sat_xfer_cnt4", xfer_cnt4, 15);
        chk("sat_err_cnt16", err_cnt, 20);
        cyc();

        // Clear coinciding with an output transfer.
        in_valid = 1'b1; onehot = 16'h0100;
        cyc();
        in_valid = 1'b0;
        cyc();
        clr_cnt = 1'b1;
        chk("clr_during_xfer_valid", out_valid, 1);
        cyc();
        clr_cnt = 1'b0;
        @(negedge clk);
        chk("clr_wins", {xfer_cnt, err_cnt, xfer_cnt4, err_cnt4}, 40'd0);
        cyc();

        // Reset with two words in flight.
        send(16'h8000);
        drain();
        in_valid = 1'b1; onehot = 16'h0002;
        cyc();
        onehot = 16'h0c00;
        cyc();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_counters", {xfer_cnt, err_cnt}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid || out_valid4) seen++;
            cyc();
        end
        chk("midrst_no_output", seen, 0);
        chk("midrst_xfer_cnt", xfer_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
